// File: rtl/score_keeper.sv
// score_keeper
//   Turns asteroid-hit pulses into points on the 9-bit score bus read by the
//   score renderer. Hits are queued in per-class pending counters. They are
//   applied only once per frame, starting at the first blanking line, so a
//   frame never shows a partially updated score.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   pixpulse           : pixel strobe (1 clk wide)
//   vcount[9:0]        : current display line
//   hit_large/med/small: 1-clk hit pulses per asteroid size class
//   game_reset         : synchronous new-game clear (high_score kept)
//   score[8:0]         : committed score
//   high_score[8:0]    : best committed score since rst
//   bonus_pulse        : 1-clk pulse on each bonus threshold crossed
//   busy               : commit sequence in progress (APPLY or DONE)
//   dropped            : sticky, a hit was lost to a full pending counter
module score_keeper #(
  parameter int unsigned PTS_LARGE   = 1,
  parameter int unsigned PTS_MED     = 2,
  parameter int unsigned PTS_SMALL   = 5,
  parameter int unsigned SCORE_MAX   = 511,
  parameter int unsigned BONUS_STEP  = 100,
  parameter int unsigned COMMIT_LINE = 480,
  parameter int unsigned PEND_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixpulse,
  input  logic [9:0] vcount,
  input  logic       hit_large,
  input  logic       hit_med,
  input  logic       hit_small,
  input  logic       game_reset,
  output logic [8:0] score,
  output logic [8:0] high_score,
  output logic       bonus_pulse,
  output logic       busy,
  output logic       dropped
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [9:0]  MAX10  = 10'(SCORE_MAX);
  localparam logic [10:0] STEP11 = 11'(BONUS_STEP);

  // Index 0 = large, 1 = med, 2 = small (also the drain priority order).
  logic [2:0][PEND_W-1:0] pend_q, pend_d, pend_left;
  logic [2:0]             hit, drain;
  logic [9:0]             pts [3];

  state_t      state_q, state_d;
  logic [8:0]  score_q, score_d;
  logic [8:0]  high_q, high_d;
  logic [10:0] next_bonus_q, next_bonus_d;
  logic        bonus_q, bonus_d;
  logic        dropped_q, dropped_d;
  logic        frame_done_q, frame_done_d;

  logic        any_pend, any_left, any_drain;
  logic [9:0]  add_pts, sum;
  logic [8:0]  new_score;

  assign hit    = {hit_small, hit_med, hit_large};
  assign pts[0] = 10'(PTS_LARGE);
  assign pts[1] = 10'(PTS_MED);
  assign pts[2] = 10'(PTS_SMALL);

  always_comb begin
    pend_d       = pend_q;
    pend_left    = pend_q;
    state_d      = state_q;
    score_d      = score_q;
    high_d       = high_q;
    next_bonus_d = next_bonus_q;
    bonus_d      = 1'b0;
    dropped_d    = dropped_q;
    // Latches once the window opens; re-arms only after leaving the line, so
    // repeated pixel strobes on COMMIT_LINE cannot start a second commit.
    frame_done_d = frame_done_q && (vcount == 10'(COMMIT_LINE));
    drain        = '0;
    any_pend     = 1'b0;
    any_left     = 1'b0;
    any_drain    = 1'b0;
    add_pts      = '0;
    sum          = '0;
    new_score    = score_q;

    for (int unsigned i = 0; i < 3; i++) begin
      any_pend = any_pend || (pend_q[i] != '0);
    end

    // Highest-priority non-empty class drains one event per APPLY cycle.
    if (state_q == APPLY) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (!any_drain && pend_q[i] != '0) begin
          drain[i]  = 1'b1;
          any_drain = 1'b1;
          add_pts   = pts[i];
        end
      end
    end

    // Exit decision ignores same-cycle hits; those wait for the next frame.
    for (int unsigned i = 0; i < 3; i++) begin
      if (drain[i]) pend_left[i] = pend_q[i] - PEND_W'(1);
      any_left = any_left || (pend_left[i] != '0);
      pend_d[i] = pend_left[i];
      if (hit[i]) begin
        if (pend_q[i] == '1) dropped_d = 1'b1;
        else                 pend_d[i] = pend_left[i] + PEND_W'(1);
      end
    end

    sum       = {1'b0, score_q} + add_pts;
    new_score = (sum > MAX10) ? MAX10[8:0] : sum[8:0];

    case (state_q)
      IDLE: begin
        if (pixpulse && vcount == 10'(COMMIT_LINE) && !frame_done_q && any_pend) begin
          state_d      = APPLY;
          frame_done_d = 1'b1;
        end
      end
      APPLY: begin
        if (any_drain) begin
          score_d = new_score;
          if ({2'b00, new_score} >= next_bonus_q) begin
            bonus_d      = 1'b1;
            next_bonus_d = next_bonus_q + STEP11;
          end
        end
        if (!any_left) state_d = DONE;
      end
      DONE: begin
        if (score_q > high_q) high_d = score_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (game_reset) begin
      score_d      = '0;
      pend_d       = '0;
      dropped_d    = 1'b0;
      bonus_d      = 1'b0;
      next_bonus_d = STEP11;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      score_q      <= '0;
      high_q       <= '0;
      next_bonus_q <= STEP11;
      bonus_q      <= 1'b0;
      dropped_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      score_q      <= score_d;
      high_q       <= high_d;
      next_bonus_q <= next_bonus_d;
      bonus_q      <= bonus_d;
      dropped_q    <= dropped_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign score       = score_q;
  assign high_score  = high_q;
  assign bonus_pulse = bonus_q;
  assign busy        = (state_q != IDLE);
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
//   Directed bench for score_keeper: queues hits mid-frame, opens the commit
//   window at line 480 and checks score, bonus, high-score and drop behaviour
//   against hand-computed values.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pixpulse = 1'b0;
  logic [9:0] vcount = 10'd0;
  logic       hit_large = 1'b0, hit_med = 1'b0, hit_small = 1'b0;
  logic       game_reset = 1'b0;
  logic [8:0] score, high_score;
  logic       bonus_pulse, busy, dropped;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int pulses, cycles;

  score_keeper #(
    .PTS_LARGE(1), .PTS_MED(2), .PTS_SMALL(5), .SCORE_MAX(511),
    .BONUS_STEP(100), .COMMIT_LINE(480), .PEND_W(4)
  ) dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .vcount(vcount),
    .hit_large(hit_large), .hit_med(hit_med), .hit_small(hit_small),
    .game_reset(game_reset), .score(score), .high_score(high_score),
    .bonus_pulse(bonus_pulse), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hits(input logic l, input logic m, input logic s);
    hit_large = l; hit_med = m; hit_small = s;
    tick();
    hit_large = 1'b0; hit_med = 1'b0; hit_small = 1'b0;
  endtask

  task automatic commit_pulse();
    vcount = 10'd480; pixpulse = 1'b1;
    tick();
    pixpulse = 1'b0; vcount = 10'd481;
  endtask

  // Runs until busy drops, counting bonus pulses and busy samples.
  task automatic drain_all(output int np, output int nc);
    np = 0; nc = 0;
    while (busy && nc < 100) begin
      np += int'(bonus_pulse);
      tick();
      nc++;
    end
    if (nc >= 100) chk("drain_timeout", int'(busy), 0);
  endtask

  task automatic pulse_game_reset();
    game_reset = 1'b1;
    tick();
    game_reset = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_score", score, 0);
    chk("rst_high", high_score, 0);
    chk("rst_bonus", bonus_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dropped", dropped, 0);
    rst = 1'b0;
    tick();

    // 3 small + 1 large mid-frame; nothing commits before line 480
    vcount = 10'd100;
    hits(0, 0, 1); hits(0, 0, 1); hits(0, 0, 1); hits(1, 0, 0);
    pixpulse = 1'b1; tick(); pixpulse = 1'b0;
    chk("t1_no_early_busy", busy, 0);
    chk("t1_no_early_score", score, 0);
    commit_pulse();
    chk("t1_apply_busy", busy, 1);
    chk("t1_apply_score", score, 0);
    tick(); chk("t1_s1", score, 1);  chk("t1_b1", busy, 1);
    tick(); chk("t1_s2", score, 6);  chk("t1_b2", busy, 1);
    tick(); chk("t1_s3", score, 11); chk("t1_b3", busy, 1);
    tick(); chk("t1_s4", score, 16); chk("t1_b4", busy, 1);
    chk("t1_high_not_yet", high_score, 0);
    tick(); chk("t1_idle", busy, 0);
    chk("t1_high", high_score, 16);

    // Simultaneous hits on all classes after a new game
    pulse_game_reset();
    chk("t2_gr_score", score, 0);
    chk("t2_gr_high", high_score, 16);
    hits(1, 1, 1);
    commit_pulse(); drain_all(pulses, cycles);
    chk("t2_score", score, 8);
    chk("t2_cycles", cycles, 4);
    chk("t2_dropped", dropped, 0);

    // Reach 97 (15 small + 7 med = 89 points), then cross 100
    for (int i = 0; i < 15; i++) hits(0, 0, 1);
    for (int i = 0; i < 7; i++) hits(0, 1, 0);
    commit_pulse(); drain_all(pulses, cycles);
    chk("t3_score97", score, 97);
    chk("t3_pulses97", pulses, 0);
    hits(0, 0, 1);
    commit_pulse();
    chk("t3_bonus_pre", bonus_pulse, 0);
    tick();
    chk("t3_score102", score, 102);
    chk("t3_bonus_on", bonus_pulse, 1);
    tick();
    chk("t3_bonus_off", bonus_pulse, 0);
    tick();
    chk("t3_high", high_score, 102);
    // +100 (1 large, 12 med, 15 small): single pulse at 200
    hits(1, 0, 0);
    for (int i = 0; i < 12; i++) hits(0, 1, 0);
    for (int i = 0; i < 15; i++) hits(0, 0, 1);
    commit_pulse(); drain_all(pulses, cycles);
    chk("t3_score202", score, 202);
    chk("t3_pulses200", pulses, 1);

    // Climb to 509 over three frames, then saturate
    for (int i = 0; i < 15; i++) hits(1, 1, 1);
    commit_pulse(); drain_all(pulses, cycles);
    chk("t4_score322", score, 322);
    chk("t4_pulses300", pulses, 1);
    for (int i = 0; i < 15; i++) hits(1, 1, 1);
    commit_pulse(); drain_all(pulses, cycles);
    chk("t4_score442", score, 442);
    chk("t4_pulses400", pulses, 1);
    for (int i = 0; i < 13; i++) hits(0, 0, 1);
    hits(0, 1, 0);
    commit_pulse(); drain_all(pulses, cycles);
    chk("t4_score509", score, 509);
    chk("t4_pulses500", pulses, 1);
    hits(0, 0, 1); hits(0, 0, 1);
    commit_pulse();
    tick();
    chk("t4_sat_first", score, 511);
    chk("t4_sat_bonus", bonus_pulse, 0);
    drain_all(pulses, cycles);
    chk("t4_sat_final", score, 511);
    chk("t4_sat_pulses", pulses, 0);
    chk("t4_high511", high_score, 511);

    // Overflow of a pending counter after a full reset
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_high", high_score, 0);
    for (int i = 0; i < 16; i++) hits(0, 0, 1);
    chk("t5_dropped_pre", dropped, 1);
    commit_pulse(); drain_all(pulses, cycles);
    chk("t5_score75", score, 75);
    chk("t5_dropped_sticky", dropped, 1);
    chk("t5_high75", high_score, 75);
    pulse_game_reset();
    chk("t5_gr_score", score, 0);
    chk("t5_gr_dropped", dropped, 0);
    chk("t5_gr_high", high_score, 75);

    // game_reset in the second APPLY cycle of a 5-event drain
    for (int i = 0; i < 5; i++) hits(0, 0, 1);
    commit_pulse();
    tick();
    chk("t6_first_event", score, 5);
    pulse_game_reset();
    chk("t6_gr_score", score, 0);
    chk("t6_gr_idle", busy, 0);
    commit_pulse();
    chk("t6_next_frame_idle", busy, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_next_frame_score", score, 0);
    chk("t6_high_kept", high_score, 75);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
